// File: rtl/riscv_pipeline_control_pkg.sv
// Shared types and helpers for the RV32 pipeline stall/flush sequencer.
// Holds the MUL/DIV sequencer state encoding, the hazard priority codes,
// and the table that maps a winning hazard onto the pipeline-register controls.
package riscv_pipeline_control_pkg;

  // MUL/DIV sequencer states
  typedef enum logic [1:0] {
    MDU_IDLE  = 2'd0,
    MDU_START = 2'd1,
    MDU_BUSY  = 2'd2,
    MDU_DONE  = 2'd3
  } mdu_state_e;

  // Hazard classes; a larger code wins when several are present at once
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_LOAD_USE = 3'd1,
    HZ_BRANCH   = 3'd2,
    HZ_MDU      = 3'd3,
    HZ_DMEM     = 3'd4
  } hazard_e;

  // Enable/flush controls for the PC and the four pipeline registers
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } pipe_ctrl_t;

  // The ID instruction needs a register that the load in EX has not produced yet.
  // x0 is never a real dependency.
  function automatic logic load_use_hit(
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_rs1_used,
    input logic       id_rs2_used,
    input logic [4:0] ex_rd,
    input logic       ex_load
  );
    return ex_load && (ex_rd != 5'd0) &&
           ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
  endfunction

  // Pipeline controls for the winning hazard; a bubble is an enable plus flush pair
  function automatic pipe_ctrl_t hazard_ctrl(input hazard_e hz);
    pipe_ctrl_t c;
    c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
          idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};
    case (hz)
      HZ_DMEM: c = '0;
      HZ_MDU: begin
        c.pc_en       = 1'b0;
        c.ifid_en     = 1'b0;
        c.idex_en     = 1'b0;
        c.exmem_flush = 1'b1;
      end
      HZ_BRANCH: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      HZ_LOAD_USE: begin
        c.pc_en      = 1'b0;
        c.ifid_en    = 1'b0;
        c.idex_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/riscv_mdu_sequencer.sv
// MUL/DIV sequencer: launches the MDU for the instruction in EX, holds EX
// while it runs, and forces completion if the unit never answers.
module riscv_mdu_sequencer #(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_ex_mdu_req,
  input  logic i_mdu_done,
  input  logic i_dmem_stall,
  output logic o_mdu_start,
  output logic o_mdu_err,
  output logic o_mdu_hold
);
  import riscv_pipeline_control_pkg::*;

  // Counter only has to reach MDU_TIMEOUT-1; it is unused when the guard is off
  localparam int TW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

  mdu_state_e    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          start_reg, start_next;
  logic          err_reg, err_next;

  // State, timeout counter and the registered start/err pulses
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= MDU_IDLE;
      timer_reg <= '0;
      start_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      start_reg <= start_next;
      err_reg   <= err_next;
    end
  end

  // Next state; a data-memory stall freezes everything except BUSY seeing done
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    start_next = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      MDU_IDLE: begin
        if (i_ex_mdu_req && !i_dmem_stall) begin
          state_next = MDU_START;
          start_next = 1'b1;
        end
      end
      MDU_START: begin
        if (!i_dmem_stall) begin
          state_next = MDU_BUSY;
          timer_next = '0;
        end
      end
      MDU_BUSY: begin
        if (i_mdu_done) begin
          state_next = MDU_DONE;
        end else if (!i_dmem_stall) begin
          if ((MDU_TIMEOUT != 0) && (timer_reg == TMO_LAST)) begin
            err_next   = 1'b1;
            state_next = MDU_DONE;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
      end
      MDU_DONE: begin
        // EX advances here, so the next request belongs to a new instruction
        if (!i_dmem_stall) state_next = MDU_IDLE;
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  assign o_mdu_start = start_reg;
  assign o_mdu_err   = err_reg;
  assign o_mdu_hold  = (state_reg == MDU_START) || (state_reg == MDU_BUSY);

endmodule

// File: rtl/riscv_pipeline_control.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Resolves data-memory waits, MUL/DIV occupancy, redirects and load-use
// hazards into PC and pipeline-register enables/flushes, and counts stalls.
module riscv_pipeline_control #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int          CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_load,
  input  logic             i_ex_br_taken,
  input  logic             i_ex_mdu_req,
  input  logic             i_mdu_done,
  input  logic             i_dmem_stall,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_exmem_flush,
  output logic             o_memwb_en,
  output logic             o_mdu_start,
  output logic             o_mdu_err,
  output logic [CNT_W-1:0] o_stall_cnt
);
  import riscv_pipeline_control_pkg::*;

  logic             mdu_hold;
  logic             load_use;
  hazard_e          hazard;
  pipe_ctrl_t       ctrl;
  logic [CNT_W-1:0] stall_cnt_reg;

  riscv_mdu_sequencer #(
    .MDU_TIMEOUT (MDU_TIMEOUT)
  ) u_mdu_seq (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_ex_mdu_req (i_ex_mdu_req),
    .i_mdu_done   (i_mdu_done),
    .i_dmem_stall (i_dmem_stall),
    .o_mdu_start  (o_mdu_start),
    .o_mdu_err    (o_mdu_err),
    .o_mdu_hold   (mdu_hold)
  );

  assign load_use = load_use_hit(i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
                                 i_ex_rd, i_ex_load);

  // Pick the highest-priority hazard; a redirect beats load-use because the
  // dependent instruction is on the wrong path, and is moot while EX holds an MDU op
  always_comb begin
    hazard = HZ_NONE;
    if (i_dmem_stall)       hazard = HZ_DMEM;
    else if (mdu_hold)      hazard = HZ_MDU;
    else if (i_ex_br_taken) hazard = HZ_BRANCH;
    else if (load_use)      hazard = HZ_LOAD_USE;
  end

  // Controls are forced inactive while reset is asserted
  always_comb begin
    ctrl = '0;
    if (i_rstn) ctrl = hazard_ctrl(hazard);
  end

  assign o_pc_en       = ctrl.pc_en;
  assign o_ifid_en     = ctrl.ifid_en;
  assign o_ifid_flush  = ctrl.ifid_flush;
  assign o_idex_en     = ctrl.idex_en;
  assign o_idex_flush  = ctrl.idex_flush;
  assign o_exmem_en    = ctrl.exmem_en;
  assign o_exmem_flush = ctrl.exmem_flush;
  assign o_memwb_en    = ctrl.memwb_en;

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_reg <= '0;
    end else if (!ctrl.pc_en && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_riscv_pipeline_control.sv
// Self-checking bench for riscv_pipeline_control: directed hazard and MDU
// scenarios followed by randomized traffic against a behavioural model.
module tb_riscv_pipeline_control;

  localparam int TMO       = 8;
  localparam int CW        = 8;
  localparam int STALL_MAX = (1 << CW) - 1;

  // Expected control vectors {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb}
  localparam logic [7:0] C_RUN    = 8'hD5;
  localparam logic [7:0] C_FREEZE = 8'h00;
  localparam logic [7:0] C_MDU    = 8'h07;
  localparam logic [7:0] C_BRANCH = 8'hFD;
  localparam logic [7:0] C_LU     = 8'h1D;

  logic          i_clk;
  logic          i_rstn;
  logic [4:0]    i_id_rs1, i_id_rs2, i_ex_rd;
  logic          i_id_rs1_used, i_id_rs2_used;
  logic          i_ex_load, i_ex_br_taken, i_ex_mdu_req, i_mdu_done, i_dmem_stall;
  logic          o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush;
  logic          o_exmem_en, o_exmem_flush, o_memwb_en, o_mdu_start, o_mdu_err;
  logic [CW-1:0] o_stall_cnt;
  logic [7:0]    obs_ctrl;

  riscv_pipeline_control #(
    .MDU_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_ex_rd       (i_ex_rd),
    .i_ex_load     (i_ex_load),
    .i_ex_br_taken (i_ex_br_taken),
    .i_ex_mdu_req  (i_ex_mdu_req),
    .i_mdu_done    (i_mdu_done),
    .i_dmem_stall  (i_dmem_stall),
    .o_pc_en       (o_pc_en),
    .o_ifid_en     (o_ifid_en),
    .o_ifid_flush  (o_ifid_flush),
    .o_idex_en     (o_idex_en),
    .o_idex_flush  (o_idex_flush),
    .o_exmem_en    (o_exmem_en),
    .o_exmem_flush (o_exmem_flush),
    .o_memwb_en    (o_memwb_en),
    .o_mdu_start   (o_mdu_start),
    .o_mdu_err     (o_mdu_err),
    .o_stall_cnt   (o_stall_cnt)
  );

  assign obs_ctrl = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
                     o_exmem_en, o_exmem_flush, o_memwb_en};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: an MDU operation occupies EX from launch until its
  // result is ready; the result then leaves EX on the next unstalled cycle.
  bit m_op, m_launched, m_result, m_start_q, m_err_q;
  int m_waited, m_stalls;

  // MDU responder and per-scenario observations
  int resp_n   = 4;
  int resp_cnt = -1;
  bit spur_done;
  int cyc, st_starts, st_errs, st_hold, start_cyc, err_cyc;
  logic [7:0] last_ctrl;
  int last_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rd = '0;
    i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0;
    i_ex_load = 1'b0; i_ex_br_taken = 1'b0; i_ex_mdu_req = 1'b0;
    i_dmem_stall = 1'b0; spur_done = 1'b0;
  endtask

  task automatic model_reset();
    m_op = 0; m_launched = 0; m_result = 0; m_start_q = 0; m_err_q = 0;
    m_waited = 0; m_stalls = 0;
  endtask

  // One clock cycle: called just after a rising edge with inputs set
  task automatic step();
    logic [7:0] e;
    bit lu, nstart, nerr;
    if (resp_cnt > 0) resp_cnt--;
    i_mdu_done = (resp_cnt == 0) || spur_done;
    if (resp_cnt == 0) resp_cnt = -1;
    @(negedge i_clk);
    lu = i_ex_load && (i_ex_rd != 0) &&
         ((i_id_rs1_used && i_id_rs1 == i_ex_rd) || (i_id_rs2_used && i_id_rs2 == i_ex_rd));
    if (i_dmem_stall)       e = C_FREEZE;
    else if (m_op)          e = C_MDU;
    else if (i_ex_br_taken) e = C_BRANCH;
    else if (lu)            e = C_LU;
    else                    e = C_RUN;
    check("ctrl", obs_ctrl, e);
    check("mdu_start", o_mdu_start, m_start_q);
    check("mdu_err", o_mdu_err, m_err_q);
    check("stall_cnt", o_stall_cnt, m_stalls);
    last_ctrl = obs_ctrl;
    last_cnt  = int'(o_stall_cnt);
    if (o_mdu_start) begin
      st_starts++; start_cyc = cyc;
      resp_cnt = (resp_n == 0) ? -1 : resp_n;
    end
    if (o_mdu_err) begin st_errs++; err_cyc = cyc; end
    if (!o_pc_en && o_exmem_flush) st_hold++;
    // advance the model over this cycle
    nstart = 0; nerr = 0;
    if (m_result) begin
      if (!i_dmem_stall) m_result = 0;
    end else if (!m_op) begin
      if (i_ex_mdu_req && !i_dmem_stall) begin m_op = 1; m_launched = 0; nstart = 1; end
    end else if (!m_launched) begin
      if (!i_dmem_stall) begin m_launched = 1; m_waited = 0; end
    end else if (i_mdu_done) begin
      m_op = 0; m_result = 1;
    end else if (!i_dmem_stall) begin
      if (TMO != 0 && m_waited + 1 == TMO) begin nerr = 1; m_op = 0; m_result = 1; end
      else m_waited++;
    end
    m_start_q = nstart;
    m_err_q   = nerr;
    if (!e[7] && m_stalls < STALL_MAX) m_stalls++;
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  // Launch one MDU op with a responder answering n cycles after start (0 = never);
  // optionally stall data memory while the result sits in EX
  task automatic run_mdu(input int n, input int done_stalls);
    int guard;
    clear_inputs();
    resp_n = n; resp_cnt = -1;
    st_starts = 0; st_errs = 0; st_hold = 0; start_cyc = -1; err_cyc = -1;
    i_ex_mdu_req = 1'b1;
    step();
    guard = 0;
    while (m_op && guard < 100) begin step(); guard++; end
    check("mdu_bound", guard < 100, 1);
    for (int j = 0; j < done_stalls; j++) begin
      i_dmem_stall = 1'b1;
      step();
      check("done_freeze", last_ctrl, C_FREEZE);
    end
    i_dmem_stall = 1'b0;
    step();
    check("done_release", last_ctrl, C_RUN);
    i_ex_mdu_req = 1'b0;
    step();
    step();
    $display("[tb] mdu n=%0d stalls=%0d hold=%0d starts=%0d errs=%0d", n, done_stalls,
             st_hold, st_starts, st_errs);
  endtask

  initial begin
    int base;
    cyc = 0;
    model_reset();
    clear_inputs();
    i_mdu_done = 1'b0;
    i_rstn = 1'b0;
    #2;
    check("rst_ctrl", obs_ctrl, 0);
    check("rst_start", o_mdu_start, 0);
    check("rst_err", o_mdu_err, 0);
    check("rst_cnt", o_stall_cnt, 0);
    #10 i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // load-use on rs2, then the x0 and unused-rs1 exemptions
    clear_inputs();
    i_ex_load = 1; i_ex_rd = 5; i_id_rs2 = 5; i_id_rs2_used = 1;
    step();
    check("lu_ctrl", last_ctrl, C_LU);
    base = last_cnt;
    clear_inputs();
    step();
    check("lu_cnt_delta", last_cnt - base, 1);
    $display("[tb] load-use rd=5 ctrl=%02h", C_LU);
    i_ex_load = 1; i_ex_rd = 0; i_id_rs2 = 0; i_id_rs2_used = 1;
    step();
    check("lu_x0", last_ctrl, C_RUN);
    clear_inputs();
    i_ex_load = 1; i_ex_rd = 5; i_id_rs1 = 5; i_id_rs1_used = 0;
    step();
    check("lu_unused", last_ctrl, C_RUN);

    // redirect overrides load-use
    clear_inputs();
    i_ex_load = 1; i_ex_rd = 5; i_id_rs2 = 5; i_id_rs2_used = 1; i_ex_br_taken = 1;
    step();
    check("br_over_lu", last_ctrl, C_BRANCH);
    $display("[tb] branch+load-use ctrl=%02h", last_ctrl);
    clear_inputs();
    step();

    // MDU done 4 cycles after start, twice in a row
    for (int r = 0; r < 2; r++) begin
      run_mdu(4, 0);
      check("mdu4_hold", st_hold, 5);
      check("mdu4_starts", st_starts, 1);
      check("mdu4_errs", st_errs, 0);
    end

    // timeout with no done
    run_mdu(0, 0);
    check("tmo_errs", st_errs, 1);
    check("tmo_err_delay", err_cyc - start_cyc, TMO + 1);
    check("tmo_hold", st_hold, TMO + 1);

    // done on the very cycle the timeout would fire: done wins
    run_mdu(TMO, 0);
    check("edge_errs", st_errs, 0);
    check("edge_hold", st_hold, TMO + 1);
    run_mdu(1, 0);
    check("mdu1_hold", st_hold, 2);

    // data-memory stall while the result sits in EX
    run_mdu(4, 3);
    check("dstall_starts", st_starts, 1);
    check("dstall_hold", st_hold, 5);

    // asynchronous reset in BUSY
    clear_inputs();
    resp_n = 0; resp_cnt = -1; st_errs = 0;
    i_ex_mdu_req = 1;
    step(); step(); step();
    check("pre_rst_busy", m_launched, 1);
    #2 i_rstn = 1'b0;
    #1;
    check("arst_ctrl", obs_ctrl, 0);
    check("arst_start", o_mdu_start, 0);
    check("arst_err", o_mdu_err, 0);
    check("arst_cnt", o_stall_cnt, 0);
    clear_inputs();
    resp_cnt = -1;
    @(posedge i_clk);
    #2;
    check("arst_hold_ctrl", obs_ctrl, 0);
    i_rstn = 1'b1;
    model_reset();
    @(posedge i_clk); #1;
    for (int k = 0; k < 12; k++) step();
    check("post_rst_cnt", o_stall_cnt, 0);
    check("post_rst_errs", st_errs, 0);
    $display("[tb] async reset in busy, stall_cnt=%0d", o_stall_cnt);

    // randomized traffic; long enough to saturate the stall counter
    for (int k = 0; k < 3000; k++) begin
      i_id_rs1      = 5'($urandom_range(0, 3));
      i_id_rs2      = 5'($urandom_range(0, 3));
      i_ex_rd       = 5'($urandom_range(0, 3));
      i_id_rs1_used = ($urandom_range(0, 3) != 0);
      i_id_rs2_used = ($urandom_range(0, 3) != 0);
      i_ex_load     = ($urandom_range(0, 9) < 4);
      i_ex_br_taken = ($urandom_range(0, 99) < 15);
      i_ex_mdu_req  = ($urandom_range(0, 99) < 10);
      i_dmem_stall  = ($urandom_range(0, 99) < 20);
      spur_done     = ($urandom_range(0, 99) < 4);
      resp_n        = $urandom_range(0, 12);
      step();
    end
    check("stall_sat", o_stall_cnt, STALL_MAX);
    $display("[tb] random phase done, stall_cnt=%0d", o_stall_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_pipeline_control.md
Name: riscv_pipeline_control

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, branch/jump redirects, data-memory wait states, and multi-cycle MUL/DIV occupancy of EX. A small FSM starts the MUL/DIV unit and holds EX until it completes, with a timeout guard.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced completion; 0 disables the timeout.
CNT_W, 32, width of the stall performance counter.

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset; asynchronous, active-low
i_id_rs1  in  5  rs1 index of the instruction in ID
i_id_rs2  in  5  rs2 index of the instruction in ID
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_rd  in  5  rd of the instruction in EX
i_ex_load  in  1  EX instruction is a load
i_ex_br_taken  in  1  EX resolves a taken branch or jump (redirect)
i_ex_mdu_req  in  1  EX instruction is MUL/DIV
i_mdu_done  in  1  MUL/DIV result valid (1-cycle pulse)
i_dmem_stall  in  1  data memory not ready; MEM must hold
o_pc_en  out  1  PC update enable
o_ifid_en  out  1  IF/ID load enable
o_ifid_flush  out  1  IF/ID load bubble
o_idex_en  out  1  ID/EX load enable
o_idex_flush  out  1  ID/EX load bubble
o_exmem_en  out  1  EX/MEM load enable
o_exmem_flush  out  1  EX/MEM load bubble
o_memwb_en  out  1  MEM/WB load enable
o_mdu_start  out  1  registered 1-cycle start pulse to the MUL/DIV unit
o_mdu_err  out  1  registered 1-cycle timeout pulse
o_stall_cnt  out  CNT_W  cycles with o_pc_en=0, saturating

Behaviour:
- Enables and flushes are combinational from inputs and FSM state, with zero latency. FSM, o_mdu_start, o_mdu_err and o_stall_cnt are registered.
- Reset: FSM=IDLE, timeout counter=0, o_mdu_start=0, o_mdu_err=0, o_stall_cnt=0.
- While i_rstn=0, all enables and flushes are forced to 0. Reset mid-MDU returns to IDLE with no start or err pulse.
- Flush only takes effect when the matching enable is 1. A bubble is an enable plus flush pair.
- Priority, highest first:
  1. i_dmem_stall: all enables=0, no flush. The pipeline freezes and the FSM holds its state, except that BUSY still accepts i_mdu_done.
  2. mdu_hold (FSM in START or BUSY): pc, ifid, idex en=0; exmem en=1 and flush=1 (bubble); memwb en=1.
  3. i_ex_br_taken (only when not mdu_hold): all en=1; ifid_flush=1, idex_flush=1. A redirect overrides load-use, because the load-use consumer is on the wrong path.
  4. load-use: i_ex_load && i_ex_rd!=0 && ((rs1_used && rs1==ex_rd) || (rs2_used && rs2==ex_rd)). Effect: pc, ifid en=0; idex en=1 and flush=1; exmem and memwb en=1.
  5. Otherwise all en=1 and all flushes=0.
- FSM states:
  - IDLE: if i_ex_mdu_req && !i_dmem_stall, go to START.
  - START: o_mdu_start=1 (registered, so it is seen the cycle after entry). Go to BUSY and clear the timeout counter.
  - BUSY: on i_mdu_done, go to DONE. Otherwise increment the timeout counter. When it equals MDU_TIMEOUT-1 (and MDU_TIMEOUT!=0), pulse o_mdu_err and go to DONE.
  - DONE: EX result is consumed and hold is released, subject to dmem_stall. Return to IDLE only when !i_dmem_stall (EX advances). DONE never restarts the same instruction.
- An N-cycle MDU operation (done N cycles after start) holds EX for N+1 cycles.
- o_stall_cnt increments on any cycle with o_pc_en=0 and i_rstn=1, and saturates at all-ones.
- i_mdu_done outside BUSY is ignored. i_ex_br_taken during mdu_hold is ignored, since the EX instruction is the MDU op.

Decomposition:
- Add FSM state encodings (IDLE=2'd0, START=2'd1, BUSY=2'd2, DONE=2'd3) and the hazard-priority constants as defines in riscv_configs.v.
- Add one sub-module, riscv_mdu_sequencer, containing the FSM, the timeout counter, o_mdu_start, o_mdu_err and mdu_hold. The top level contains the hazard compare, the priority mux and the stall counter.

Test Plan:
1. Load-use: ex_load=1, ex_rd=5, id_rs2=5, rs2_used=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt increments by 1. Repeat with ex_rd=0 -> no stall.
2. Branch plus load-use in the same cycle: br_taken=1 with the case-1 hazard -> all en=1, ifid_flush=idex_flush=1, no stall.
3. MDU with done 4 cycles after start: EX held 5 cycles, exmem bubble on each of them; mdu_start is exactly one pulse; FSM returns to IDLE; next op restarts cleanly.
4. MDU_TIMEOUT=8, no i_mdu_done -> o_mdu_err pulses once, 8 cycles after BUSY entry; FSM goes to DONE, then IDLE; hold released.
5. dmem_stall asserted for 3 cycles during DONE -> all en=0 and the FSM stays in DONE with no second mdu_start; it exits to IDLE on the first cycle with the stall clear.
6. Assert i_rstn=0 asynchronously while in BUSY -> outputs zero immediately; after release, IDLE, stall_cnt=0, no err pulse.
